ram64x12_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sits directly upstream of a RAM64x12 hard block and drives its write and read ports. It turns the RAM into a 64-entry first-word-fall-through (FWFT) queue with valid/ready handshakes on both sides. The RAM's registered read-data stage serves as the FIFO output register.

---
 rtl/ram64x12_fifo_ctrl.sv | 79 +++++++
 tb/tb_ram64x12_fifo_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ram64x12_fifo_ctrl.sv
// ram64x12_fifo_ctrl: 64-entry FWFT FIFO controller in front of a RAM64x12 block.
// Define RAM64X12_FIFO_LEVEL_EN to build LEVEL, ALMOST_FULL and ALMOST_EMPTY.
module ram64x12_fifo_ctrl
`ifdef RAM64X12_FIFO_LEVEL_EN
#(
    parameter int AFULL_TH  = 60,
    parameter int AEMPTY_TH = 2
)
`endif
(
    input  logic        CLK,
    input  logic        ARST_N,
    input  logic        FLUSH,
    input  logic [11:0] I_DATA,
    input  logic        I_VALID,
    output logic        I_READY,
    output logic        O_VALID,
    input  logic        O_READY,
    output logic [11:0] O_DATA,
    output logic [6:0]  LEVEL,
    output logic        ALMOST_FULL,
    output logic        ALMOST_EMPTY,
    output logic [5:0]  RAM_W_ADDR,
    output logic [11:0] RAM_W_DATA,
    output logic        RAM_W_EN,
    output logic [5:0]  RAM_R_ADDR,
    output logic        RAM_R_DATA_EN,
    input  logic [11:0] RAM_R_DATA
);
    logic [5:0] wr_ptr, rd_ptr;
    logic [6:0] ram_cnt;
    logic       wr_fire, rd_fire;

    always_comb begin
        I_READY       = (ram_cnt != 7'd64) & ~FLUSH;
        wr_fire       = I_VALID & I_READY;
        rd_fire       = (ram_cnt != 7'd0) & (~O_VALID | O_READY) & ~FLUSH;
        RAM_W_EN      = wr_fire;
        RAM_W_ADDR    = wr_ptr;
        RAM_W_DATA    = I_DATA;
        RAM_R_DATA_EN = rd_fire;
        RAM_R_ADDR    = rd_ptr;
        O_DATA        = RAM_R_DATA;
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            O_VALID <= 1'b0;
        end else if (FLUSH) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            O_VALID <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + 6'(wr_fire);
            rd_ptr  <= rd_ptr + 6'(rd_fire);
            ram_cnt <= ram_cnt + 7'(wr_fire) - 7'(rd_fire);
            O_VALID <= rd_fire ? 1'b1 : O_READY ? 1'b0 : O_VALID;
        end
    end

`ifdef RAM64X12_FIFO_LEVEL_EN
    // The RAM's read-data register counts as one extra storage slot.
    always_comb begin
        LEVEL        = ram_cnt + 7'(O_VALID);
        ALMOST_FULL  = LEVEL >= 7'(AFULL_TH);
        ALMOST_EMPTY = LEVEL <= 7'(AEMPTY_TH);
    end
`else
    always_comb begin
        LEVEL        = '0;
        ALMOST_FULL  = 1'b0;
        ALMOST_EMPTY = 1'b0;
    end
`endif
endmodule

// File: tb/tb_ram64x12_fifo_ctrl.sv
// tb_ram64x12_fifo_ctrl: randomized bench with a queue-based FIFO model and a RAM64x12 model.
module tb_ram64x12_fifo_ctrl;
    logic        CLK = 1'b0;
    logic        ARST_N = 1'b0;
    logic        FLUSH = 1'b0;
    logic [11:0] I_DATA = '0;
    logic        I_VALID = 1'b0;
    logic        I_READY;
    logic        O_VALID;
    logic        O_READY = 1'b0;
    logic [11:0] O_DATA;
    logic [6:0]  LEVEL;
    logic        ALMOST_FULL, ALMOST_EMPTY;
    logic [5:0]  RAM_W_ADDR, RAM_R_ADDR;
    logic [11:0] RAM_W_DATA;
    logic        RAM_W_EN, RAM_R_DATA_EN;
    logic [11:0] RAM_R_DATA;

    logic [11:0] mem [64];
    logic [11:0] ram_q [$];
    logic        ov;
    logic [11:0] od;
    int          wcnt, rcnt;
    int          vectors = 0;
    int          errs = 0;

    ram64x12_fifo_ctrl dut (
        .CLK(CLK), .ARST_N(ARST_N), .FLUSH(FLUSH), .I_DATA(I_DATA), .I_VALID(I_VALID),
        .I_READY(I_READY), .O_VALID(O_VALID), .O_READY(O_READY), .O_DATA(O_DATA),
        .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
        .RAM_W_ADDR(RAM_W_ADDR), .RAM_W_DATA(RAM_W_DATA), .RAM_W_EN(RAM_W_EN),
        .RAM_R_ADDR(RAM_R_ADDR), .RAM_R_DATA_EN(RAM_R_DATA_EN), .RAM_R_DATA(RAM_R_DATA)
    );

    always #5 CLK = ~CLK;

    // RAM64x12 with unregistered read address and registered read data
    always @(posedge CLK) begin
        if (RAM_W_EN) mem[RAM_W_ADDR] <= RAM_W_DATA;
        if (RAM_R_DATA_EN) RAM_R_DATA <= mem[RAM_R_ADDR];
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ram_q.delete();
        ov = 1'b0;
        wcnt = 0;
        rcnt = 0;
    endtask

    task automatic check_flags(input int lvl);
`ifdef RAM64X12_FIFO_LEVEL_EN
        chk("level", 12'(LEVEL), 12'(lvl));
        chk("almost_full", 12'(ALMOST_FULL), 12'(lvl >= 60));
        chk("almost_empty", 12'(ALMOST_EMPTY), 12'(lvl <= 2));
`else
        chk("level", 12'(LEVEL), 12'(0));
        chk("almost_full", 12'(ALMOST_FULL), 12'(0));
        chk("almost_empty", 12'(ALMOST_EMPTY), 12'(0));
`endif
    endtask

    task automatic step(input logic iv, input logic [11:0] id, input logic ordy, input logic fl);
        logic er, wf, rf;
        @(negedge CLK);
        I_VALID = iv;
        I_DATA  = id;
        O_READY = ordy;
        FLUSH   = fl;
        er = (ram_q.size() < 64) && !fl;
        wf = iv && er;
        rf = (ram_q.size() > 0) && (!ov || ordy) && !fl;
        #1;
        chk("i_ready", 12'(I_READY), 12'(er));
        chk("o_valid", 12'(O_VALID), 12'(ov));
        if (ov) chk("o_data", O_DATA, od);
        check_flags(ram_q.size() + int'(ov));
        chk("ram_w_en", 12'(RAM_W_EN), 12'(wf));
        if (wf) begin
            chk("ram_w_addr", 12'(RAM_W_ADDR), 12'(wcnt % 64));
            chk("ram_w_data", RAM_W_DATA, id);
        end
        chk("ram_r_data_en", 12'(RAM_R_DATA_EN), 12'(rf));
        if (rf) chk("ram_r_addr", 12'(RAM_R_ADDR), 12'(rcnt % 64));
        @(posedge CLK);
        if (fl) model_reset();
        else begin
            if (rf) begin
                od = ram_q.pop_front();
                rcnt++;
            end
            if (wf) begin
                ram_q.push_back(id);
                wcnt++;
            end
            ov = rf ? 1'b1 : ordy ? 1'b0 : ov;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_o_valid", 12'(O_VALID), 12'(0));
        chk("rst_ram_w_en", 12'(RAM_W_EN), 12'(0));
        chk("rst_ram_r_data_en", 12'(RAM_R_DATA_EN), 12'(0));
        check_flags(0);
    endtask

    initial begin
        model_reset();
        #3;
        check_reset_outputs();
        @(negedge CLK);
        ARST_N = 1'b1;
        #1;
        chk("rst_i_ready", 12'(I_READY), 12'(1));
        // single word through an empty FIFO
        step(1'b1, 12'hA5C, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 12'h000, 1'b1, 1'b0);
        // fill to capacity with the consumer stalled
        for (int i = 0; i < 68; i++) step(1'b1, 12'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 70; i++) step(1'b0, 12'h000, 1'b1, 1'b0);
        // sustained streaming across pointer wrap
        for (int i = 0; i < 200; i++) step(1'b1, 12'(i * 7 + 3), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 12'h000, 1'b1, 1'b0);
        // random valid and ready stalls
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 12'($urandom), 1'($urandom_range(0, 3) != 0 ? i % 2 : 0), 1'b0);
        for (int i = 0; i < 70; i++) step(1'b0, 12'h000, 1'b1, 1'b0);
        // flush with ten words held while a write is offered
        for (int i = 0; i < 10; i++) step(1'b1, 12'($urandom), 1'b0, 1'b0);
        step(1'b0, 12'h000, 1'b0, 1'b0);
        step(1'b1, 12'hFFF, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 1'b1, 1'b0);
        // asynchronous reset in the middle of a stream
        for (int i = 0; i < 20; i++) step(1'b1, 12'($urandom), 1'($urandom), 1'b0);
        @(negedge CLK);
        I_VALID = 1'b0;
        O_READY = 1'b0;
        #1;
        ARST_N = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(negedge CLK);
        ARST_N = 1'b1;
        step(1'b1, 12'h123, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 12'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 12'h000, 1'b1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
